// File: rtl/sound_voice_mixer.sv
// Square-wave voice bank with per-note durations, mixed into one saturated, registered signed sample.
// Optional feature: define SOUND_DECAY_EN for a per-tick linear amplitude decay on each voice.
module sound_voice_mixer #(
    parameter int NUM_VOICES  = 4,
    parameter int DIV_W       = 20,
    parameter int DUR_W       = 16,
    parameter int TICK_DIV    = 50000,
    parameter int AMP_W       = 32,
    parameter int AMPLITUDE   = 100000000,
    parameter int DECAY_SHIFT = 6
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  cmd_valid,
    output logic                                                  cmd_ready,
    input  logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] cmd_voice,
    input  logic                                                  cmd_stop,
    input  logic [DIV_W-1:0]                                      cmd_half_period,
    input  logic [DUR_W-1:0]                                      cmd_duration,
    output logic [NUM_VOICES-1:0]                                 voice_active,
    output logic [NUM_VOICES-1:0]                                 voice_done,
    output logic signed [AMP_W-1:0]                               sound_out
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUM_W = AMP_W + 5;
    localparam logic [AMP_W-1:0] LEVEL_MAX  = AMP_W'(AMPLITUDE);
    localparam logic [AMP_W-1:0] DECAY_STEP = AMP_W'(AMPLITUDE >> DECAY_SHIFT);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        $signed({{(SUM_W - AMP_W + 1){1'b0}}, {(AMP_W - 1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        $signed({{(SUM_W - AMP_W + 1){1'b1}}, {(AMP_W - 1){1'b0}}});

    logic [PRE_W-1:0]      presc;
    logic                  tick;
    logic                  cmd_fire;
    logic                  cmd_load;

    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] phase;
    logic [NUM_VOICES-1:0] done;
    logic [DIV_W-1:0]      half [NUM_VOICES];
    logic [DIV_W-1:0]      cnt [NUM_VOICES];
    logic [DUR_W-1:0]      remain [NUM_VOICES];
    logic [AMP_W-1:0]      level [NUM_VOICES];

    logic signed [SUM_W-1:0] mix_sum;

    // Free-running duration tick; commands never disturb it.
    assign tick = (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign cmd_ready = ~reset;
    assign cmd_fire  = cmd_valid & cmd_ready & (int'(cmd_voice) < NUM_VOICES);
    assign cmd_load  = ~cmd_stop & (cmd_half_period >= DIV_W'(2));

    // A command to a voice takes priority over that voice's own timing in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= '0;
            phase  <= '0;
            done   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                half[v]   <= '0;
                cnt[v]    <= '0;
                remain[v] <= '0;
            end
        end else begin
            done <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cmd_fire && int'(cmd_voice) == v) begin
                    if (cmd_load) begin
                        active[v] <= 1'b1;
                        phase[v]  <= 1'b1;
                        cnt[v]    <= '0;
                        half[v]   <= cmd_half_period;
                        remain[v] <= cmd_duration;
                    end else begin
                        active[v] <= 1'b0;
                        phase[v]  <= 1'b0;
                    end
                end else if (active[v]) begin
                    if (cnt[v] == half[v] - 1'b1) begin
                        phase[v] <= ~phase[v];
                        cnt[v]   <= '0;
                    end else begin
                        cnt[v] <= cnt[v] + 1'b1;
                    end
                    if (tick && remain[v] != '0) begin
                        remain[v] <= remain[v] - 1'b1;
                        if (remain[v] == DUR_W'(1)) begin
                            active[v] <= 1'b0;
                            done[v]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SOUND_DECAY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                level[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cmd_fire && cmd_load && int'(cmd_voice) == v) begin
                    level[v] <= LEVEL_MAX;
                end else if (active[v] && tick) begin
                    level[v] <= (level[v] > DECAY_STEP) ? level[v] - DECAY_STEP : '0;
                end
            end
        end
    end
`else
    logic unused_decay_step;
    assign unused_decay_step = ^DECAY_STEP;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            level[v] = LEVEL_MAX;
        end
    end
`endif

    // Five guard bits cover up to 16 full-scale voices before clamping.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active[v]) begin
                if (phase[v]) begin
                    mix_sum = mix_sum + $signed({{(SUM_W - AMP_W){1'b0}}, level[v]});
                end else begin
                    mix_sum = mix_sum - $signed({{(SUM_W - AMP_W){1'b0}}, level[v]});
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sound_out <= '0;
        end else if (mix_sum > SAT_MAX) begin
            sound_out <= SAT_MAX[AMP_W-1:0];
        end else if (mix_sum < SAT_MIN) begin
            sound_out <= SAT_MIN[AMP_W-1:0];
        end else begin
            sound_out <= mix_sum[AMP_W-1:0];
        end
    end

    assign voice_active = active;
    assign voice_done   = done;

endmodule

// File: doc/sound_voice_mixer.md
SOUND_VOICE_MIXER -- requirements
Module: sound_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of independent square-wave voices (1..16).
REQ-002 SHALL have parameter DIV_W, default 20, half-period counter width in clock cycles.
REQ-003 SHALL have parameter DUR_W, default 16, note-duration width in ticks.
REQ-004 SHALL have parameter TICK_DIV, default 50000, clock cycles per duration tick (1 ms at 50 MHz).
REQ-005 SHALL have parameter AMP_W, default 32, signed output width.
REQ-006 SHALL have parameter AMPLITUDE, default 100000000, per-voice peak magnitude.
REQ-007 SHALL have port: clock  input  1  single rising-edge clock.
REQ-008 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port: cmd_valid  input  1  command present.
REQ-010 SHALL have port: cmd_ready  output  1  command may be accepted.
REQ-011 SHALL have port: cmd_voice  input  max(1,$clog2(NUM_VOICES))  target voice index.
REQ-012 SHALL have port: cmd_stop  input  1  1 = stop voice, 0 = load note.
REQ-013 SHALL have port: cmd_half_period  input  DIV_W  half-period in cycles (50 MHz / (2*freq)).
REQ-014 SHALL have port: cmd_duration  input  DUR_W  length in ticks; 0 = sustain until stop.
REQ-015 SHALL have port: voice_active  output  NUM_VOICES  per-voice playing flag.
REQ-016 SHALL have port: voice_done  output  NUM_VOICES  one-cycle pulse on natural expiry.
REQ-017 SHALL have port: sound_out  output  AMP_W  signed, registered mixed sample.

Function
REQ-018 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be 1 whenever reset is low.
REQ-019 SHALL ignore commands whose cmd_voice >= NUM_VOICES.
REQ-020 Load (cmd_stop=0, cmd_half_period>=2) SHALL set the voice active, phase high, period counter 0, remaining duration = cmd_duration, at the accepting edge.
REQ-021 Load to an already-active voice SHALL retrigger it per REQ-020 without a voice_done pulse.
REQ-022 Load with cmd_half_period < 2, or stop (cmd_stop=1), SHALL make the voice inactive at the accepting edge, no voice_done pulse.
REQ-023 Each active voice SHALL toggle phase when its counter equals half_period-1 and clear the counter, else increment; full period = 2*half_period cycles.
REQ-024 A free-running prescaler SHALL emit a one-cycle tick every TICK_DIV cycles, unaffected by commands.
REQ-025 On a tick, every active voice with nonzero remaining duration SHALL decrement; on the decrement from 1 to 0 the voice SHALL go inactive and pulse its voice_done bit for exactly that cycle.
REQ-026 A command and an expiry tick on the same voice in the same cycle: the command SHALL win, no voice_done pulse.
REQ-027 Voice contribution SHALL be +level when phase high, -level when low, 0 when inactive.
REQ-028 sound_out SHALL be the saturated signed sum of contributions, clamped to [-2^(AMP_W-1), 2^(AMP_W-1)-1], registered: command accepted at edge N changes sound_out at edge N+1.

Reset
REQ-029 Reset SHALL asynchronously clear sound_out, voice_active, voice_done, all counters, prescaler and phases to 0, including mid-note; first tick SHALL occur TICK_DIV cycles after reset release.

Configuration
REQ-030 With macro SOUND_DECAY_EN defined, each voice SHALL hold level, loaded to AMPLITUDE on load, reduced by AMPLITUDE>>DECAY_SHIFT (parameter, default 6) on each tick, floored at 0; the voice stays active at level 0 until expiry/stop.
REQ-031 Without SOUND_DECAY_EN, level SHALL equal AMPLITUDE constantly and DECAY_SHIFT SHALL have no effect.

Verification (TICK_DIV=10, NUM_VOICES=4, no decay unless stated)
REQ-032 Load voice 0, half_period=4, duration=0 -> from edge N+1 sound_out alternates +100000000 x4 cycles / -100000000 x4 cycles indefinitely.
REQ-033 Load voice 1, half_period=3, duration=3 -> voice_done[1] single-cycle pulse and voice_active[1] falls on the third tick after acceptance; sound_out 0 next cycle.
REQ-034 AMPLITUDE=2^30, four voices loaded identically in consecutive cycles, half_period=1000 -> sound_out reaches 32'h7FFFFFFF while all high, 32'h80000000 while all low.
REQ-035 Stop to active voice 2 in same cycle as its expiry tick -> voice_active[2]=0, voice_done[2] never pulses.
REQ-036 Assert reset mid-note with 3 voices active -> sound_out=0, voice_active=0 immediately, before next clock edge.
REQ-037 SOUND_DECAY_EN, AMPLITUDE=6400, DECAY_SHIFT=6 -> magnitude drops 100 per tick, reaches 0 after 64 ticks, voice_active stays 1.
